// File: rtl/wave_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wave_pkg
// Brief   : Shared types, widths and sample conversion for wave_capture.
// Rev     : 1.0  initial release
// ============================================================================
package wave_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PIXEL_W  = 8;
  localparam int ADDR_W   = 9;
  localparam int INDEX_W  = ADDR_W - 1;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_WAIT   = 2'b10
  } state_t;

  // Two's complement to offset binary: flip the sign, keep the top magnitude bits.
  function automatic logic [PIXEL_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] sample);
    return {~sample[SAMPLE_W-1], sample[SAMPLE_W-2 -: PIXEL_W-1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wave_capture_if.sv
`default_nettype none
// ============================================================================
// Module  : wave_capture_if
// Brief   : Sample input / sample RAM write bundle for wave_capture.
// Rev     : 1.0  initial release
// ============================================================================
interface wave_capture_if;
  import wave_pkg::*;

  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;
  logic [ADDR_W-1:0]   write_address;
  logic                write_enable;
  logic [PIXEL_W-1:0]  write_sample;
  logic                read_index;

  modport master (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );

  modport slave (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

endinterface
`default_nettype wire

// File: rtl/wave_capture_trigger.sv
`default_nettype none
// ============================================================================
// Module  : wave_trigger
// Brief   : Positive zero-crossing detector with optional forced trigger
//           after TIMEOUT_SAMPLES armed strobes (WAVE_CAPTURE_TIMEOUT_EN).
// Rev     : 1.0  initial release
// ============================================================================
module wave_trigger #(
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_strobe,
  input  wire logic i_armed,
  input  wire logic i_track,
  input  wire logic i_clear,
  input  wire logic i_sample_neg,
  output logic      o_trigger
);

  logic r_prev_neg;
  logic w_cross;
  logic w_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_neg <= 1'b0;
    end else if (i_clear) begin
      r_prev_neg <= 1'b0;
    end else if (i_track) begin
      r_prev_neg <= i_sample_neg;
    end
  end

  assign w_cross = i_armed & i_strobe & r_prev_neg & ~i_sample_neg;

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_SAMPLES) + 1;

  logic [CNT_W-1:0] r_timeout_cnt;

  // Cleared whenever ARMED is (re)entered, so it only ever counts one armed stretch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout_cnt <= '0;
    end else if (i_clear || o_trigger) begin
      r_timeout_cnt <= '0;
    end else if (i_armed && i_strobe) begin
      r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end
  end

  assign w_timeout = i_armed & i_strobe & (r_timeout_cnt == CNT_W'(TIMEOUT_SAMPLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign o_trigger = w_cross | w_timeout;

  if (TIMEOUT_SAMPLES < 1) begin : g_bad_timeout
    $error("wave_trigger: TIMEOUT_SAMPLES must be at least 1");
  end

endmodule
`default_nettype wire

// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
// Module  : wave_capture
// Brief   : Captures 256 samples per trigger into the hidden bank of a
//           double-buffered sample RAM. Optional timeout: WAVE_CAPTURE_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module wave_capture
  import wave_pkg::*;
#(
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  wire logic       clk,
  input  wire logic       reset,
  wave_capture_if.master  bus
);

  state_t               r_state;
  state_t               w_next_state;
  logic [INDEX_W-1:0]   r_count;
  logic [INDEX_W-1:0]   w_next_count;
  logic [INDEX_W-1:0]   w_wr_index;
  logic                 r_read_index;
  logic                 r_wr_en;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [PIXEL_W-1:0]   r_wr_data;
  logic                 w_trigger;
  logic                 w_write;
  logic                 w_toggle;
  logic                 w_armed;
  logic                 w_track;

  assign w_armed = (r_state == ST_ARMED);
  assign w_track = bus.new_sample_ready & (r_state != ST_WAIT);

  wave_trigger #(
    .TIMEOUT_SAMPLES (TIMEOUT_SAMPLES)
  ) u_trigger (
    .clk          (clk),
    .reset        (reset),
    .i_strobe     (bus.new_sample_ready),
    .i_armed      (w_armed),
    .i_track      (w_track),
    .i_clear      (w_toggle),
    .i_sample_neg (bus.new_sample_in[SAMPLE_W-1]),
    .o_trigger    (w_trigger)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ARMED;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_wr_index   = r_count;
    w_write      = 1'b0;
    w_toggle     = 1'b0;
    case (r_state)
      ST_ARMED: begin
        if (w_trigger) begin
          w_write      = 1'b1;
          w_wr_index   = '0;
          w_next_count = INDEX_W'(1);
          w_next_state = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (bus.new_sample_ready) begin
          w_write      = 1'b1;
          w_next_count = r_count + 1'b1;
          if (r_count == '1) begin
            w_next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Strobes are dropped here; the bank swap waits for the display to go idle.
        if (bus.wave_display_idle) begin
          w_toggle     = 1'b1;
          w_next_state = ST_ARMED;
        end
      end
      default: begin
        w_next_state = ST_ARMED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_index <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_wr_en <= w_write;
      if (w_toggle) begin
        r_read_index <= ~r_read_index;
      end
      if (w_write) begin
        r_wr_addr <= {~r_read_index, w_wr_index};
        r_wr_data <= to_offset_binary(bus.new_sample_in);
      end
    end
  end

  assign bus.write_enable  = r_wr_en;
  assign bus.write_address = r_wr_addr;
  assign bus.write_sample  = r_wr_data;
  assign bus.read_index    = r_read_index;

endmodule
`default_nettype wire

// File: tb/tb_wave_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_wave_capture
// Brief   : Self-checking bench for wave_capture: vector table, directed
//           corner sequences and randomized traffic against a reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_wave_capture;
  import wave_pkg::*;

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam int TB_TO      = 8;
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam int TB_TO      = 1024;
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam int M_ARMED  = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_WAIT   = 2;

  typedef struct {
    bit          stb;
    logic [15:0] s;
    bit          idle;
    bit          exp_we;
    logic [8:0]  exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  int m_mode, m_idx, m_to, m_addr, m_data;
  bit m_bank, m_prev_neg, m_we;

  wave_capture_if bus ();

  wave_capture #(
    .TIMEOUT_SAMPLES (TB_TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic state_t exp_state();
    case (m_mode)
      M_ACTIVE: return ST_ACTIVE;
      M_WAIT:   return ST_WAIT;
      default:  return ST_ARMED;
    endcase
  endfunction

  task automatic emit(input int idx, input int v);
    m_we   = 1'b1;
    m_addr = (m_bank ? 0 : 256) + idx;
    m_data = (v + 32768) / 256;
  endtask

  task automatic model_step(input bit rst_i, input bit stb, input logic [15:0] s, input bit idle);
    bit trig;
    int v;
    m_we = 1'b0;
    if (rst_i) begin
      m_mode = M_ARMED; m_idx = 0; m_to = 0; m_bank = 1'b0; m_prev_neg = 1'b0;
      m_addr = 0; m_data = 0;
      return;
    end
    v = int'($signed(s));
    case (m_mode)
      M_ARMED: if (stb) begin
        trig = m_prev_neg && (v >= 0);
        m_to++;
        if (TIMEOUT_ON && m_to == TB_TO) trig = 1'b1;
        if (trig) begin
          emit(0, v);
          m_idx = 1; m_mode = M_ACTIVE; m_to = 0;
        end
        m_prev_neg = (v < 0);
      end
      M_ACTIVE: if (stb) begin
        emit(m_idx, v);
        m_prev_neg = (v < 0);
        m_idx++;
        if (m_idx == 256) m_mode = M_WAIT;
      end
      default: if (idle) begin
        m_bank = !m_bank; m_prev_neg = 1'b0; m_mode = M_ARMED; m_to = 0;
      end
    endcase
  endtask

  // One clock: drive at negedge, let the edge pass, compare against the model.
  task automatic step(input bit rst_i, input bit stb, input logic [15:0] s, input bit idle);
    @(negedge clk);
    reset                 = rst_i;
    bus.new_sample_ready  = stb;
    bus.new_sample_in     = s;
    bus.wave_display_idle = idle;
    model_step(rst_i, stb, s, idle);
    @(posedge clk);
    #1;
    check("model_we", 32'(bus.write_enable), 32'(m_we));
    if (m_we) begin
      check("model_addr", 32'(bus.write_address), 32'(m_addr));
      check("model_data", 32'(bus.write_sample), 32'(m_data));
    end
    check("model_read_index", 32'(bus.read_index), 32'(m_bank));
    check("model_state", 32'(dut.r_state), 32'(exp_state()));
  endtask

  initial begin
    vec_t tbl[8];
    int   wn, last_addr, first_addr, gaps, prev_addr, first_at;

    reset = 1'b1;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = '0;
    bus.wave_display_idle = 1'b0;

    tbl[0] = '{1'b1, 16'hF000, 1'b0, 1'b0, 9'h000, 8'h00};
    tbl[1] = '{1'b1, 16'h0100, 1'b0, 1'b1, 9'h100, 8'h81};
    tbl[2] = '{1'b1, 16'h8000, 1'b0, 1'b1, 9'h101, 8'h00};
    tbl[3] = '{1'b1, 16'h0000, 1'b0, 1'b1, 9'h102, 8'h80};
    tbl[4] = '{1'b1, 16'h7FFF, 1'b0, 1'b1, 9'h103, 8'hFF};
    tbl[5] = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 9'h104, 8'h7F};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 9'h000, 8'h00};
    tbl[7] = '{1'b1, 16'h1234, 1'b0, 1'b1, 9'h105, 8'h92};

    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 16'h8000, 1'b1);
    check("reset_we",    32'(bus.write_enable),  32'd0);
    check("reset_addr",  32'(bus.write_address), 32'd0);
    check("reset_data",  32'(bus.write_sample),  32'd0);
    check("reset_ri",    32'(bus.read_index),    32'd0);
    check("reset_state", 32'(dut.r_state),       32'(ST_ARMED));

    // trigger and conversion vectors, back to back
    for (int i = 0; i < 8; i++) begin
      step(1'b0, tbl[i].stb, tbl[i].s, tbl[i].idle);
      check($sformatf("tbl%0d_we", i), 32'(bus.write_enable), 32'(tbl[i].exp_we));
      if (tbl[i].exp_we) begin
        check($sformatf("tbl%0d_addr", i), 32'(bus.write_address), 32'(tbl[i].exp_addr));
        check($sformatf("tbl%0d_data", i), 32'(bus.write_sample),  32'(tbl[i].exp_data));
      end
    end
    check("tbl_state_active", 32'(dut.r_state), 32'(ST_ACTIVE));

    // fill the rest of the bank with full-scale negative samples
    wn = 0; last_addr = -1;
    for (int i = 0; i < 300 && m_mode == M_ACTIVE; i++) begin
      step(1'b0, 1'b1, 16'h8000, 1'b0);
      if (bus.write_enable) begin
        wn++;
        last_addr = int'(bus.write_address);
        check("fill_data", 32'(bus.write_sample), 32'h00);
      end
    end
    check("fill_writes", 32'(wn), 32'd250);
    check("fill_last_addr", 32'(last_addr), 32'h1FF);
    check("fill_state_wait", 32'(dut.r_state), 32'(ST_WAIT));

    // WAIT ignores strobes until idle; strobe+idle toggles without writing
    wn = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 16'($urandom), 1'b0);
      if (bus.write_enable) wn++;
    end
    check("wait_no_writes", 32'(wn), 32'd0);
    step(1'b0, 1'b1, 16'h0100, 1'b1);
    check("toggle_no_write", 32'(bus.write_enable), 32'd0);
    check("toggle_ri", 32'(bus.read_index), 32'd1);
    check("toggle_state", 32'(dut.r_state), 32'(ST_ARMED));

    // second capture lands in bank 0, one write per cycle
    step(1'b0, 1'b1, 16'hF000, 1'b0);
    wn = 0; gaps = 0; first_addr = -1; prev_addr = -1; last_addr = -1;
    for (int i = 0; i < 300 && (i == 0 || m_mode == M_ACTIVE); i++) begin
      step(1'b0, 1'b1, (i == 0) ? 16'h0000 : 16'($urandom), 1'b0);
      if (bus.write_enable) begin
        wn++;
        if (first_addr < 0) first_addr = int'(bus.write_address);
        if (prev_addr >= 0 && int'(bus.write_address) != prev_addr + 1) gaps++;
        prev_addr = int'(bus.write_address);
        last_addr = prev_addr;
      end else begin
        gaps++;
      end
    end
    check("cap2_writes", 32'(wn), 32'd256);
    check("cap2_first_addr", 32'(first_addr), 32'h000);
    check("cap2_last_addr", 32'(last_addr), 32'h0FF);
    check("cap2_gaps", 32'(gaps), 32'd0);

    // constant positive input never crosses zero
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    wn = 0; first_at = -1; first_addr = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, 16'h1000, 1'b0);
      if (bus.write_enable && first_at < 0) begin
        first_at = i;
        first_addr = int'(bus.write_address);
        check("timeout_data", 32'(bus.write_sample), 32'h90);
      end
      if (bus.write_enable) wn++;
    end
`ifdef WAVE_CAPTURE_TIMEOUT_EN
    check("timeout_first_at", 32'(first_at), 32'd8);
    check("timeout_first_addr", 32'(first_addr), 32'h100);
`else
    check("no_cross_writes", 32'(wn), 32'd0);
`endif

    // reset mid-capture
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'hF000, 1'b0);
    wn = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, (i == 0) ? 16'h0100 : 16'($urandom), 1'b0);
      if (bus.write_enable) wn++;
    end
    check("pre_reset_writes", 32'(wn), 32'd100);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 16'($urandom), 1'b1);
      check("midreset_we", 32'(bus.write_enable), 32'd0);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    check("postreset_we", 32'(bus.write_enable), 32'd0);
    check("postreset_ri", 32'(bus.read_index), 32'd0);
    check("postreset_state", 32'(dut.r_state), 32'(ST_ARMED));

    // randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 999) == 0, $urandom_range(0, 9) < 7,
           16'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 Parameter TIMEOUT_SAMPLES, default 1024, sets how many samples are seen while ARMED before a forced trigger; used only when WAVE_CAPTURE_TIMEOUT_EN is defined.
REQ-002 Port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, synchronous active-high reset.
REQ-004 Port new_sample_ready, input, 1, single-cycle strobe meaning new_sample_in is valid this cycle.
REQ-005 Port new_sample_in, input, 16, signed two's-complement audio sample.
REQ-006 Port wave_display_idle, input, 1, high while the display is outside its active drawing region.
REQ-007 Port write_address, output, 9, sample RAM write address {bank, index[7:0]}.
REQ-008 Port write_enable, output, 1, sample RAM write strobe.
REQ-009 Port write_sample, output, 8, unsigned offset-binary sample value.
REQ-010 Port read_index, output, 1, bank the display reads; capture always writes bank ~read_index.

Function
REQ-011 States SHALL be ARMED, ACTIVE and WAIT, held in one registered state variable.
REQ-012 ARMED: a positive zero crossing occurs when the previous accepted sample was negative (bit 15 = 1) and the current strobed sample is non-negative; on a crossing the block SHALL write the current sample at index 0, set count to 1 and enter ACTIVE.
REQ-013 ACTIVE: each strobed sample SHALL be written at index count, then count increments; the write at index 255 SHALL move the state to WAIT.
REQ-014 WAIT: no writes; strobes are ignored; the first cycle with wave_display_idle = 1 SHALL toggle read_index, clear the previous-sign flag and enter ARMED.
REQ-015 The previous-sign flag SHALL update on every strobe in ARMED and ACTIVE and SHALL be left unchanged in WAIT.
REQ-016 write_sample SHALL equal {~new_sample_in[15], new_sample_in[14:8]}, so 0x8000 maps to 0x00 and 0x0000 maps to 0x80.
REQ-017 write_enable, write_address and write_sample SHALL be registered, valid the cycle after the accepting strobe, with write_enable high for exactly one cycle per write.
REQ-018 write_address[8] SHALL equal ~read_index as it was on the accepting strobe cycle.
REQ-019 Exactly 256 writes SHALL occur per capture; count is 8 bits and never wraps inside one capture.
REQ-020 If a strobe and wave_display_idle are both high in WAIT, the bank toggle takes priority and the sample is not written.
REQ-021 Back-to-back strobes on consecutive cycles SHALL each be written; throughput is one sample per cycle.

Reset
REQ-022 On reset: state ARMED, read_index 0, count 0, previous-sign flag 0, write_enable 0, write_address 0, write_sample 0, timeout counter 0.
REQ-023 Reset asserted mid-capture SHALL abandon the capture with no further writes and without toggling read_index.

Configuration
REQ-024 Macro WAVE_CAPTURE_TIMEOUT_EN: when defined, a counter SHALL count strobes in ARMED; on the TIMEOUT_SAMPLES-th strobe without a crossing, that sample SHALL be treated as a trigger. The counter clears on every entry to ARMED.
REQ-025 Without WAVE_CAPTURE_TIMEOUT_EN, ARMED waits indefinitely for a crossing and no timeout logic is present.

Structure
REQ-026 The shared package wave_pkg SHALL hold the state enum, SAMPLE_W = 16, PIXEL_W = 8, ADDR_W = 9 and the offset-binary conversion function.
REQ-027 One sub-module, wave_trigger, SHALL hold the previous-sign register, the crossing detector and the optional timeout counter, and output a single-cycle trigger.

Verification
REQ-028 Reset, then strobe 0xF000 followed by 0x0100 -> write_enable one cycle later with write_address 0x100 and write_sample 0x81; state ACTIVE.
REQ-029 After the trigger, 255 more strobes of 0x8000 -> addresses 0x101 through 0x1FF, each with data 0x00; state WAIT after the last write.
REQ-030 In WAIT, 10 strobes with wave_display_idle = 0 -> no write_enable; then wave_display_idle = 1 -> read_index becomes 1; the next capture writes addresses 0x000 through 0x0FF.
REQ-031 Strobes of constant 0x1000 with no negative sample -> no writes; with WAVE_CAPTURE_TIMEOUT_EN and TIMEOUT_SAMPLES = 8 -> a write at index 0 on the 8th strobe.
REQ-032 Reset asserted after 100 ACTIVE writes -> write_enable stays 0, read_index stays 0 and state is ARMED.
REQ-033 Strobes on consecutive cycles -> one write per cycle at consecutive addresses with no drops.
